firebird7_in_gate1_tessent_sync_data_mux: RTL and testbench

//  Multi-channel IJTAG/functional data mux, NUM_CH lanes of WIDTH bits, with a sequenced switchover.
//  On a select change, each lane freezes its output for SETTLE_CYCLES tck cycles before handing over.

---
 rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv | 18 +
 rtl/firebird7_in_gate1_tessent_data_mux_lane.sv | 97 +++++++++
 rtl/firebird7_in_gate1_tessent_sync_data_mux.sv | 73 +++++++
 tb/tb_firebird7_in_gate1_tessent_sync_data_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and constants for the gate1 IJTAG/functional data mux.
// Holds the per-lane state encoding and the settle-counter width.
package firebird7_in_gate1_tessent_data_mux_pkg;

    typedef enum logic [1:0] {
        FUNC   = 2'd0,
        HOLD_I = 2'd1,
        IJTAG  = 2'd2,
        HOLD_F = 2'd3
    } mux_state_e;

    localparam int CNT_W = 4;

    function automatic logic is_hold(input mux_state_e s);
        return (s == HOLD_I) || (s == HOLD_F);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_lane.sv
// One mux lane: switchover FSM, hold register, settle down-counter and output select.
//
// state  | meaning
// FUNC   | functional data passed straight through
// HOLD_I | output frozen on hreg, heading to IJTAG
// IJTAG  | IJTAG data passed straight through
// HOLD_F | output frozen on hreg, heading back to functional
module firebird7_in_gate1_tessent_data_mux_lane
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sel,
    input  logic [WIDTH-1:0] i_func,
    input  logic [WIDTH-1:0] i_ijtag,
    output logic [WIDTH-1:0] o_data,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    mux_state_e       r_state;
    mux_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_hreg;
    logic [WIDTH-1:0] w_hreg_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FUNC;
            r_hreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hreg  <= w_hreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A select flip during a hold aborts back to the source we came from.
    always_comb begin
        w_state_nxt = r_state;
        w_hreg_nxt  = r_hreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FUNC: begin
                if (i_sel) begin
                    w_state_nxt = HOLD_I;
                    w_hreg_nxt  = i_func;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            HOLD_I: begin
                if (!i_sel) begin
                    w_state_nxt = FUNC;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = IJTAG;
                end
            end
            IJTAG: begin
                if (!i_sel) begin
                    w_state_nxt = HOLD_F;
                    w_hreg_nxt  = i_ijtag;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            HOLD_F: begin
                if (i_sel) begin
                    w_state_nxt = IJTAG;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = FUNC;
                end
            end
            default: w_state_nxt = FUNC;
        endcase
    end

    always_comb begin
        o_data = r_hreg;
        case (r_state)
            FUNC:    o_data = i_func;
            IJTAG:   o_data = i_ijtag;
            default: o_data = r_hreg;
        endcase
    end

    assign o_busy = is_hold(r_state);

endmodule

// File: rtl/firebird7_in_gate1_tessent_sync_data_mux.sv
// NUM_CH-lane IJTAG/functional data mux with per-lane sequenced switchover.
// Optional capture register enabled by defining FIREBIRD7_DATA_MUX_CAPTURE_EN.
module firebird7_in_gate1_tessent_sync_data_mux
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    ijtag_tck,
    input  logic                    ijtag_reset,
    input  logic [NUM_CH-1:0]       ijtag_select,
    input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
    input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]       switch_busy,
    output logic                    all_settled
`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
    ,
    input  logic                    capture_en,
    output logic [NUM_CH*WIDTH-1:0] capture_data
`endif
);

    if (WIDTH < 1 || NUM_CH < 1 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_param
        $fatal(1, "data_mux: illegal parameters WIDTH=%0d NUM_CH=%0d SETTLE_CYCLES=%0d",
               WIDTH, NUM_CH, SETTLE_CYCLES);
    end

    logic [WIDTH-1:0] w_lane_data [NUM_CH];
    logic             w_lane_busy [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        firebird7_in_gate1_tessent_data_mux_lane #(
            .WIDTH         (WIDTH),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_lane (
            .i_clk   (ijtag_tck),
            .i_rst_n (ijtag_reset),
            .i_sel   (ijtag_select[c]),
            .i_func  (functional_data_in[c*WIDTH +: WIDTH]),
            .i_ijtag (ijtag_data_in[c*WIDTH +: WIDTH]),
            .o_data  (w_lane_data[c]),
            .o_busy  (w_lane_busy[c])
        );
    end

    always_comb begin
        data_out    = '0;
        switch_busy = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            data_out[c*WIDTH +: WIDTH] = w_lane_data[c];
            switch_busy[c]             = w_lane_busy[c];
        end
    end

    assign all_settled = ~|switch_busy;

`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
    logic [NUM_CH*WIDTH-1:0] r_capture;

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            r_capture <= '0;
        end else if (capture_en) begin
            r_capture <= data_out;
        end
    end

    assign capture_data = r_capture;
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_sync_data_mux.sv
// Directed bench for the gate1 data mux (WIDTH=3, NUM_CH=4, SETTLE_CYCLES=2).
// Capture checks are included when FIREBIRD7_DATA_MUX_CAPTURE_EN is defined.
module tb_firebird7_in_gate1_tessent_sync_data_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sel;
    logic [2:0]  f [4];
    logic [2:0]  j [4];
    logic [11:0] func_bus;
    logic [11:0] ijtag_bus;
    logic [11:0] data_out;
    logic [3:0]  switch_busy;
    logic        all_settled;
`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
    logic        capture_en;
    logic [11:0] capture_data;
`endif

    int total = 0;
    int bad   = 0;

    assign func_bus  = {f[3], f[2], f[1], f[0]};
    assign ijtag_bus = {j[3], j[2], j[1], j[0]};

    always #5 clk = ~clk;

    firebird7_in_gate1_tessent_sync_data_mux #(
        .WIDTH(3), .NUM_CH(4), .SETTLE_CYCLES(2)
    ) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst_n),
        .ijtag_select       (sel),
        .functional_data_in (func_bus),
        .ijtag_data_in      (ijtag_bus),
        .data_out           (data_out),
        .switch_busy        (switch_busy),
        .all_settled        (all_settled)
`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
        ,
        .capture_en         (capture_en),
        .capture_data       (capture_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] lane(input int c);
        return data_out[c*3 +: 3];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel   = 4'b0000;
        f[0] = 3'b101; f[1] = 3'b001; f[2] = 3'b010; f[3] = 3'b100;
        j[0] = 3'b110; j[1] = 3'b011; j[2] = 3'b111; j[3] = 3'b000;
`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
        capture_en = 1'b0;
`endif

        // reset behaviour
        #2;
        chk("rst_lane0", 16'(lane(0)), 16'(3'b101));
        chk("rst_busy", 16'(switch_busy), 16'h0);
        chk("rst_settled", 16'(all_settled), 16'h1);
`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
        chk("rst_capture", 16'(capture_data), 16'h0);
`endif
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_lane0", 16'(lane(0)), 16'(3'b101));
        chk("post_rst_busy", 16'(switch_busy), 16'h0);

        // FUNC -> IJTAG switchover on lane 0
        f[0] = 3'b011; j[0] = 3'b110;
        sel[0] = 1'b1;
        tick();
        f[0] = 3'b001;
        #1;
        chk("sw_hold1_out", 16'(lane(0)), 16'(3'b011));
        chk("sw_hold1_busy", 16'(switch_busy), 16'(4'b0001));
        chk("sw_hold1_settled", 16'(all_settled), 16'h0);
        tick();
        chk("sw_hold2_out", 16'(lane(0)), 16'(3'b011));
        chk("sw_hold2_busy", 16'(switch_busy), 16'(4'b0001));
        tick();
        chk("sw_ijtag_out", 16'(lane(0)), 16'(3'b110));
        chk("sw_ijtag_busy", 16'(switch_busy), 16'h0);
        chk("sw_ijtag_settled", 16'(all_settled), 16'h1);
        j[0] = 3'b111;
        #1;
        chk("ijtag_zero_lat", 16'(lane(0)), 16'(3'b111));

        // one-cycle deselect pulse while in IJTAG: abort back
        f[0] = 3'b000;
        sel[0] = 1'b0;
        tick();
        sel[0] = 1'b1;
        j[0] = 3'b100;
        #1;
        chk("abortf_hold_out", 16'(lane(0)), 16'(3'b111));
        chk("abortf_busy", 16'(switch_busy), 16'(4'b0001));
        tick();
        chk("abortf_back_out", 16'(lane(0)), 16'(3'b100));
        chk("abortf_back_busy", 16'(switch_busy), 16'h0);
        tick();
        chk("abortf_quiet", 16'(switch_busy), 16'h0);

        // lanes 0 and 3 switch together, lane 1 stays functional
        f[0] = 3'b011; j[0] = 3'b110;
        f[3] = 3'b010; j[3] = 3'b101;
        sel[0] = 1'b0; sel[3] = 1'b1;
        tick();
        f[3] = 3'b000; j[0] = 3'b000; f[1] = 3'b111;
        #1;
        chk("par_busy1", 16'(switch_busy), 16'(4'b1001));
        chk("par_settled1", 16'(all_settled), 16'h0);
        chk("par_lane0_hold", 16'(lane(0)), 16'(3'b110));
        chk("par_lane3_hold", 16'(lane(3)), 16'(3'b010));
        chk("par_lane1_func", 16'(lane(1)), 16'(3'b111));
        tick();
        f[1] = 3'b001;
        #1;
        chk("par_busy2", 16'(switch_busy), 16'(4'b1001));
        chk("par_settled2", 16'(all_settled), 16'h0);
        chk("par_lane1_func2", 16'(lane(1)), 16'(3'b001));
        tick();
        chk("par_done_busy", 16'(switch_busy), 16'h0);
        chk("par_done_settled", 16'(all_settled), 16'h1);
        chk("par_lane0_func", 16'(lane(0)), 16'(3'b011));
        j[3] = 3'b110;
        #1;
        chk("par_lane3_ijtag", 16'(lane(3)), 16'(3'b110));

        // reset in the middle of HOLD_I
        j[0] = 3'b101;
        sel[0] = 1'b1;
        tick();
        chk("midrst_pre_busy", 16'(switch_busy), 16'(4'b0001));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 16'(switch_busy), 16'h0);
        chk("midrst_settled", 16'(all_settled), 16'h1);
        chk("midrst_lane0", 16'(lane(0)), 16'(3'b011));
        chk("midrst_lane3", 16'(lane(3)), 16'(3'b000));
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_busy1", 16'(switch_busy), 16'(4'b1001));
        chk("restart_lane0", 16'(lane(0)), 16'(3'b011));
        tick();
        chk("restart_busy2", 16'(switch_busy), 16'(4'b1001));
        tick();
        chk("restart_done_busy", 16'(switch_busy), 16'h0);
        chk("restart_lane0_ij", 16'(lane(0)), 16'(3'b101));

        // one-cycle select pulse from FUNC on lane 2
        sel[2] = 1'b1;
        tick();
        sel[2] = 1'b0;
        chk("pulse_busy", 16'(switch_busy), 16'(4'b0100));
        tick();
        chk("pulse_abort_busy", 16'(switch_busy), 16'h0);
        chk("pulse_abort_out", 16'(lane(2)), 16'(3'b010));
        tick();
        chk("pulse_quiet", 16'(switch_busy), 16'h0);

`ifdef FIREBIRD7_DATA_MUX_CAPTURE_EN
        // both sources agree per lane so data_out is 0xABC whatever the lane state
        f[0] = 3'b100; j[0] = 3'b100;
        f[1] = 3'b111; j[1] = 3'b111;
        f[2] = 3'b010; j[2] = 3'b010;
        f[3] = 3'b101; j[3] = 3'b101;
        #1;
        chk("cap_src", 16'(data_out), 16'h0ABC);
        capture_en = 1'b1;
        tick();
        capture_en = 1'b0;
        chk("cap_take", 16'(capture_data), 16'h0ABC);
        f[0] = 3'b000; j[0] = 3'b000;
        tick();
        chk("cap_hold", 16'(capture_data), 16'h0ABC);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
